divm_result_writer: RTL and testbench

DIVM_RESULT_WRITER -- requirements
Module: divm_result_writer

---
 rtl/divm_result_writer.sv | 152 +++++++++++++++
 tb/tb_divm_result_writer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/divm_result_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | divm_result_writer: stores a pair of words to memory (A then B) with     |
// | optional idle gaps. Optional: DIVM_WR_ALIGN_CHECK_EN rejects misaligned.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module divm_result_writer #(
    parameter int ADDR_W   = 32,
    parameter int WAIT_CYC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] data_a,
    input  logic [ADDR_W-1:0] data_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_A   = 3'd1,
        WAIT_A = 3'd2,
        WR_B   = 3'd3,
        WAIT_B = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Counter is loaded with the number of extra wait cycles after the first.
    localparam logic [1:0] C_WAIT_RELOAD = (WAIT_CYC > 0) ? 2'(WAIT_CYC - 1) : 2'd0;

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_a_q,    addr_a_d;
    logic [ADDR_W-1:0]   addr_b_q,    addr_b_d;
    logic [ADDR_W-1:0]   data_a_q,    data_a_d;
    logic [ADDR_W-1:0]   data_b_q,    data_b_d;
    logic [1:0]          cnt_q,       cnt_d;
    logic                misal_q,     misal_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [ADDR_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_wr_q,    mem_wr_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                err_q,       err_d;
    logic                w_misaligned;

`ifdef DIVM_WR_ALIGN_CHECK_EN
    assign w_misaligned = (addr_a[1:0] != 2'b00) || (addr_b[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        data_a_d    = data_a_q;
        data_b_d    = data_b_q;
        cnt_d       = cnt_q;
        misal_d     = misal_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wr_d    = 1'b0;
        busy_d      = (state_q != IDLE);
        done_d      = (state_q == DONE);
        err_d       = (state_q == DONE) && misal_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_a_d = addr_a;
                    addr_b_d = addr_b;
                    data_a_d = data_a;
                    data_b_d = data_b;
                    misal_d  = w_misaligned;
                    state_d  = w_misaligned ? DONE : WR_A;
                end
            end
            WR_A: begin
                mem_wr_d    = 1'b1;
                mem_addr_d  = addr_a_q;
                mem_wdata_d = data_a_q;
                cnt_d       = C_WAIT_RELOAD;
                state_d     = (WAIT_CYC == 0) ? WR_B : WAIT_A;
            end
            WAIT_A: begin
                if (cnt_q == 2'd0) state_d = WR_B;
                else               cnt_d   = cnt_q - 2'd1;
            end
            WR_B: begin
                mem_wr_d    = 1'b1;
                mem_addr_d  = addr_b_q;
                mem_wdata_d = data_b_q;
                cnt_d       = C_WAIT_RELOAD;
                state_d     = (WAIT_CYC == 0) ? DONE : WAIT_B;
            end
            WAIT_B: begin
                if (cnt_q == 2'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            cnt_q       <= 2'd0;
            misal_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            cnt_q       <= cnt_d;
            misal_q     <= misal_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_q    <= mem_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr    = mem_wr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_divm_result_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_divm_result_writer: two writers (WAIT_CYC 0 and 2) against a          |
// | timeline-based reference model. Honours DIVM_WR_ALIGN_CHECK_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_divm_result_writer;

    localparam int N_DUT = 2;
    localparam int WAITS [N_DUT] = '{0, 2};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr_a = '0, addr_b = '0, data_a = '0, data_b = '0;

    logic [31:0] o_addr  [N_DUT];
    logic [31:0] o_wdata [N_DUT];
    logic        o_wr    [N_DUT];
    logic        o_busy  [N_DUT];
    logic        o_done  [N_DUT];
    logic        o_err   [N_DUT];

    logic [31:0] a0, d0, a2, d2;
    logic        wr0, bz0, dn0, er0, wr2, bz2, dn2, er2;

    divm_result_writer #(.ADDR_W(32), .WAIT_CYC(0)) u_w0 (
        .clk(clk), .reset(reset), .start(start),
        .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
        .mem_addr(a0), .mem_wdata(d0), .mem_wr(wr0),
        .busy(bz0), .done(dn0), .err(er0)
    );

    divm_result_writer #(.ADDR_W(32), .WAIT_CYC(2)) u_w2 (
        .clk(clk), .reset(reset), .start(start),
        .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
        .mem_addr(a2), .mem_wdata(d2), .mem_wr(wr2),
        .busy(bz2), .done(dn2), .err(er2)
    );

    assign o_addr[0] = a0;  assign o_wdata[0] = d0;  assign o_wr[0] = wr0;
    assign o_busy[0] = bz0; assign o_done[0]  = dn0; assign o_err[0] = er0;
    assign o_addr[1] = a2;  assign o_wdata[1] = d2;  assign o_wr[1] = wr2;
    assign o_busy[1] = bz2; assign o_done[1]  = dn2; assign o_err[1] = er2;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each accepted request is a timeline measured from its
    // acceptance edge; outputs follow from the offset into that timeline.
    int          cyc = 0;
    bit          active [N_DUT];
    bit          mis    [N_DUT];
    int          acc    [N_DUT];
    logic [31:0] la_a [N_DUT], la_b [N_DUT], ld_a [N_DUT], ld_b [N_DUT];
    logic [31:0] e_addr [N_DUT], e_data [N_DUT];
    bit          e_wr [N_DUT], e_busy [N_DUT], e_done [N_DUT], e_err [N_DUT];

    initial begin
        for (int i = 0; i < N_DUT; i++) begin
            active[i] = 0; mis[i] = 0; acc[i] = 0;
            e_addr[i] = '0; e_data[i] = '0;
            e_wr[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0;
        end
    end

    task automatic model_step(input int i);
        int w, t, d;
        w = WAITS[i];
        e_wr[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0;
        if (!reset) begin
            active[i] = 0;
            e_addr[i] = '0;
            e_data[i] = '0;
        end else begin
            if (active[i]) begin
                d = cyc - acc[i];
                t = mis[i] ? 1 : 3 + 2 * w;
                if (d <= t) begin
                    e_busy[i] = 1;
                    if (!mis[i] && d == 1)     begin e_wr[i] = 1; e_addr[i] = la_a[i]; e_data[i] = ld_a[i]; end
                    if (!mis[i] && d == 2 + w) begin e_wr[i] = 1; e_addr[i] = la_b[i]; e_data[i] = ld_b[i]; end
                    if (d == t) begin e_done[i] = 1; e_err[i] = mis[i]; end
                end else begin
                    active[i] = 0;
                end
            end
            if (!active[i] && start) begin
                active[i] = 1;
                acc[i]    = cyc;
                la_a[i] = addr_a; la_b[i] = addr_b; ld_a[i] = data_a; ld_b[i] = data_b;
`ifdef DIVM_WR_ALIGN_CHECK_EN
                mis[i] = (addr_a[1:0] != 2'b00) || (addr_b[1:0] != 2'b00);
`else
                mis[i] = 1'b0;
`endif
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < N_DUT; i++) model_step(i);
    end

    logic [31:0] mem0 [logic [31:0]];

    always @(negedge clk) begin
        for (int i = 0; i < N_DUT; i++) begin
            check_eq($sformatf("u%0d.mem_wr", i),    {31'd0, o_wr[i]},   {31'd0, e_wr[i]});
            check_eq($sformatf("u%0d.busy", i),      {31'd0, o_busy[i]}, {31'd0, e_busy[i]});
            check_eq($sformatf("u%0d.done", i),      {31'd0, o_done[i]}, {31'd0, e_done[i]});
            check_eq($sformatf("u%0d.err", i),       {31'd0, o_err[i]},  {31'd0, e_err[i]});
            check_eq($sformatf("u%0d.mem_addr", i),  o_addr[i],  e_addr[i]);
            check_eq($sformatf("u%0d.mem_wdata", i), o_wdata[i], e_data[i]);
        end
        if (wr0 === 1'b1) mem0[a0] = d0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    task automatic launch(input logic [31:0] aa, input logic [31:0] da,
                          input logic [31:0] ab, input logic [31:0] db);
        addr_a = aa; data_a = da; addr_b = ab; data_b = db;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Scramble inputs: latched copies must be unaffected.
        addr_a = $urandom; data_a = $urandom; addr_b = $urandom; data_b = $urandom;
        repeat (10) tick();
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        launch(32'h10, 32'hAAAA_0001, 32'h14, 32'h5555_FFFE);
        launch(32'h20, 32'h1, 32'h20, 32'h2);
        check_eq("mem_0x20", mem0.exists(32'h20) ? mem0[32'h20] : 32'hDEAD_BEEF, 32'h2);

        // start held for 10 cycles; data_a changes right after acceptance
        addr_a = 32'h40; data_a = 32'h1111_1111; addr_b = 32'h44; data_b = 32'h2222_2222;
        start = 1'b1;
        tick();
        data_a = 32'h3333_3333;
        repeat (9) tick();
        start = 1'b0;
        repeat (10) tick();

        // reset during WR_B of the zero-wait writer
        addr_a = 32'h80; data_a = 32'hCAFE_0001; addr_b = 32'h84; data_b = 32'hCAFE_0002;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (10) tick();

        launch(32'h10, 32'h0BAD_0001, 32'h22, 32'h0BAD_0002);
        launch(32'h13, 32'h0BAD_0003, 32'h30, 32'h0BAD_0004);

        for (int k = 0; k < 1500; k++) begin
            start  = ($urandom_range(0, 2) == 0);
            addr_a = rnd_addr();
            addr_b = ($urandom_range(0, 5) == 0) ? addr_a : rnd_addr();
            data_a = $urandom;
            data_b = $urandom;
            reset  = ($urandom_range(0, 59) != 0);
            tick();
        end
        start = 1'b0;
        reset = 1'b1;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
